print_spooler: RTL and testbench

PRINT_SPOOLER -- requirements
Module: print_spooler

---
 rtl/print_spooler_pkg.sv | 29 ++
 rtl/print_spooler_byte_fifo.sv | 62 ++++++
 rtl/print_spooler.sv | 95 +++++++++
 tb/tb_print_spooler.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/print_spooler_pkg.sv
// Shared I/O address map for bus devices plus the spooler status-byte layout.
// Every device decoding the CPU bus takes its port addresses from here.
package print_spooler_pkg;

    localparam logic [15:0] IO_SPOOL_DATA_ADDR   = 16'h2000;
    localparam logic [15:0] IO_SPOOL_STATUS_ADDR = 16'h2001;

    localparam int STAT_FULL_BIT  = 7;
    localparam int STAT_EMPTY_BIT = 6;
    localparam int STAT_OVF_BIT   = 5;
    localparam int STAT_BUSY_BIT  = 4;

    function automatic logic [7:0] pack_status(
        input logic       full,
        input logic       empty,
        input logic       overflow,
        input logic       busy,
        input logic [3:0] count
    );
        logic [7:0] s;
        s                 = {4'b0000, count};
        s[STAT_FULL_BIT]  = full;
        s[STAT_EMPTY_BIT] = empty;
        s[STAT_OVF_BIT]   = overflow;
        s[STAT_BUSY_BIT]  = busy;
        return s;
    endfunction

endpackage

// File: rtl/print_spooler_byte_fifo.sv
// Byte FIFO with wrapping pointers and a separate occupancy counter.
// Push is ignored when full and pop is ignored when empty.
module byte_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [7:0]    i_data,
    output logic [7:0]    o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= AW'(0);
            r_rd_ptr <= AW'(0);
            r_count  <= CW'(0);
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; emptiness is tracked by the counter alone.
    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == CW'(0));
    assign o_count = r_count;

endmodule

// File: rtl/print_spooler.sv
// CPU-bus print spooler: buffers bytes written to an I/O port and paces them
// out to a printer handshake, with a readable status byte.
module print_spooler
    import print_spooler_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DEPTH         = 8,
    parameter int PACING_CYCLES = 4,
    parameter logic [ADDRESS_WIDTH-1:0] DATA_ADDRESS   = ADDRESS_WIDTH'(IO_SPOOL_DATA_ADDR),
    parameter logic [ADDRESS_WIDTH-1:0] STATUS_ADDRESS = ADDRESS_WIDTH'(IO_SPOOL_STATUS_ADDR)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic                     mio,
    inout  wire  [7:0]               data,
    input  logic                     readRequest,
    input  logic                     writeRequest,
    output logic [7:0]               charData,
    output logic                     charValid,
    input  logic                     charReady
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (PACING_CYCLES < 1) ? 1 : $clog2(PACING_CYCLES + 1);

    logic          w_bus_write;
    logic          w_status_read;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_ovf_event;
    logic          w_busy;
    logic [CW-1:0] w_count;
    logic [3:0]    w_count_nib;
    logic [7:0]    w_status;
    logic          r_overflow;
    logic [PW-1:0] r_pace;

    // Gating with reset keeps the bus released and blocks pushes while in reset.
    assign w_bus_write   = !reset && !mio && !writeRequest && (address == DATA_ADDRESS);
    assign w_status_read = !reset && !mio && !readRequest && (address == STATUS_ADDRESS);

    assign w_push      = w_bus_write && !w_full;
    assign w_ovf_event = w_bus_write && w_full;
    assign w_busy      = (r_pace != PW'(0));
    assign charValid   = !w_empty && !w_busy;
    assign w_pop       = charValid && charReady;

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (data),
        .o_head  (charData),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_count_nib = 4'(w_count);
    assign w_status    = pack_status(w_full, w_empty, r_overflow, w_busy, w_count_nib);
    assign data        = w_status_read ? w_status : 8'hzz;

    // Pacing counter: reloaded on every transfer, counts down to zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pace <= PW'(0);
        end else if (w_pop) begin
            r_pace <= PW'(PACING_CYCLES);
        end else if (w_busy) begin
            r_pace <= r_pace - PW'(1);
        end else begin
            r_pace <= r_pace;
        end
    end

    // Sticky overflow: a new drop wins over the clear-on-status-read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_event) begin
            r_overflow <= 1'b1;
        end else if (w_status_read) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= r_overflow;
        end
    end

endmodule

// File: tb/tb_print_spooler.sv
// Self-checking bench for print_spooler: directed scenarios plus a random
// phase, all compared against a queue-based model of the spooler rules.
module tb_print_spooler;

    localparam int DEPTH = 8;
    localparam int PACE  = 4;
    localparam logic [15:0] A_DATA = 16'h2000;
    localparam logic [15:0] A_STAT = 16'h2001;
    localparam logic [7:0]  BUS_IDLE = 8'hFF;  // released bus reads high via pull-ups

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] address = 16'h0000;
    logic        mio = 1'b1;
    logic        readRequest = 1'b1;
    logic        writeRequest = 1'b1;
    logic [7:0]  charData;
    logic        charValid;
    logic        charReady = 1'b0;
    logic [7:0]  tb_data = 8'h00;
    logic        tb_drive = 1'b0;
    wire  [7:0]  data;

    assign data = tb_drive ? tb_data : 8'hzz;

    for (genvar gi = 0; gi < 8; gi++) begin : g_bus_pull
        pullup (data[gi]);
    end

    print_spooler dut (
        .clock        (clock),
        .reset        (reset),
        .address      (address),
        .mio          (mio),
        .data         (data),
        .readRequest  (readRequest),
        .writeRequest (writeRequest),
        .charData     (charData),
        .charValid    (charValid),
        .charReady    (charReady)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [7:0]  q[$];
    logic        m_ovf = 1'b0;
    int          m_pace = 0;
    logic [7:0]  last_bus;
    bit          tracing = 1'b0;
    logic [7:0]  seen[$];
    int          gaps[$];
    int          gap_cnt = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [7:0] exp_status();
        int n;
        n = q.size();
        return {n == DEPTH, n == 0, m_ovf, m_pace != 0, 4'(n)};
    endfunction

    function automatic bit m_valid_now();
        return (q.size() > 0) && (m_pace == 0);
    endfunction

    // One bus cycle: settle, compare DUT against model, advance model, cross edge.
    task automatic step();
        bit m_valid, m_wr, m_rd, m_xfer, m_full;
        #2;
        m_valid = m_valid_now();
        m_wr = !mio && !writeRequest && (address == A_DATA);
        m_rd = !mio && !readRequest && (address == A_STAT);
        last_bus = data;
        chk("charValid", {7'b0, charValid}, {7'b0, m_valid});
        if (m_valid) chk("charData", charData, q[0]);
        if (!tb_drive) chk("data_bus", data, m_rd ? exp_status() : BUS_IDLE);
        if (tracing) begin
            if (charValid && charReady) begin
                seen.push_back(charData);
                if (seen.size() > 1) gaps.push_back(gap_cnt);
                gap_cnt = 0;
            end else if (!charValid && seen.size() > 0) begin
                gap_cnt++;
            end
        end
        m_xfer = m_valid && charReady;
        m_full = (q.size() == DEPTH);
        if (m_xfer) begin
            void'(q.pop_front());
            m_pace = PACE;
        end else if (m_pace > 0) begin
            m_pace--;
        end
        if (m_wr && !m_full) q.push_back(tb_data);
        if (m_wr && m_full) m_ovf = 1'b1;
        else if (m_rd) m_ovf = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic bus_idle();
        mio = 1'b1;
        readRequest = 1'b1;
        writeRequest = 1'b1;
        tb_drive = 1'b0;
        address = 16'h0000;
    endtask

    task automatic do_write(input logic [7:0] b, input logic m = 1'b0, input logic [15:0] a = A_DATA);
        mio = m;
        address = a;
        writeRequest = 1'b0;
        tb_data = b;
        tb_drive = 1'b1;
        step();
        bus_idle();
    endtask

    task automatic do_read(input logic [15:0] a, input logic m = 1'b0);
        mio = m;
        address = a;
        readRequest = 1'b0;
        step();
        bus_idle();
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_pace = 0;
    endtask

    initial begin
        bus_idle();
        // Reset held: bus released even with a status read requested.
        #3;
        mio = 1'b0;
        address = A_STAT;
        readRequest = 1'b0;
        #1;
        chk("rst_bus_z", data, BUS_IDLE);
        chk("rst_valid", {7'b0, charValid}, 8'h00);
        repeat (2) @(posedge clock);
        #1;
        bus_idle();
        reset = 1'b0;
        model_reset();

        // Three characters paced out in order; first write is at the first edge after release.
        charReady = 1'b1;
        tracing = 1'b1;
        do_write(8'h41);
        do_write(8'h42);
        do_write(8'h43);
        repeat (25) step();
        tracing = 1'b0;
        chk("xfer_count", 8'(seen.size()), 8'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < seen.size()) chk("xfer_order", seen[i], 8'h41 + 8'(i));
        end
        chk("gap_count", 8'(gaps.size()), 8'd2);
        for (int i = 0; i < gaps.size(); i++) chk("gap_len", 8'(gaps[i]), 8'd4);

        // Ignored bus cycles.
        do_write(8'h55, 1'b1, A_DATA);
        do_read(A_DATA);
        do_write(8'h66, 1'b0, A_STAT);
        do_read(A_STAT, 1'b1);
        do_read(A_STAT);
        chk("mio_ignored", last_bus, 8'h40);

        // Overflow with the printer stalled.
        charReady = 1'b0;
        for (int i = 0; i < 9; i++) do_write(8'($urandom));
        do_read(A_STAT);
        chk("full_ovf", last_bus, 8'hA8);
        do_read(A_STAT);
        chk("ovf_cleared", last_bus, 8'h88);

        // Drain to empty and idle.
        charReady = 1'b1;
        for (int i = 0; i < 80 && !(q.size() == 0 && m_pace == 0); i++) step();
        repeat (2) step();
        do_read(A_STAT);
        chk("drained", last_bus, 8'h40);

        // Push coinciding with transfer at count 3, enough times to wrap pointers.
        charReady = 1'b0;
        for (int i = 0; i < 3; i++) do_write(8'($urandom));
        charReady = 1'b1;
        for (int k = 0; k < 20; k++) begin
            for (int w = 0; w < 10 && !m_valid_now(); w++) step();
            do_write(8'($urandom));
        end
        do_read(A_STAT);
        chk("wrap_count", last_bus & 8'h0F, 8'h03);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            charReady = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 6))
                0, 1:    do_write(8'($urandom));
                2:       do_read(A_STAT);
                3:       do_read(A_DATA);
                4:       do_write(8'($urandom), 1'b1, A_DATA);
                5:       do_write(8'($urandom), 1'b0, A_STAT);
                default: step();
            endcase
        end

        // Reset mid-stream with five bytes queued.
        charReady = 1'b1;
        for (int i = 0; i < 80 && !(q.size() == 0 && m_pace == 0); i++) step();
        charReady = 1'b0;
        for (int i = 0; i < 5; i++) do_write(8'($urandom));
        charReady = 1'b1;
        #2;
        reset = 1'b1;
        mio = 1'b0;
        address = A_STAT;
        readRequest = 1'b0;
        #1;
        chk("rst_mid_valid", {7'b0, charValid}, 8'h00);
        chk("rst_mid_bus", data, BUS_IDLE);
        model_reset();
        @(posedge clock);
        #1;
        bus_idle();
        reset = 1'b0;
        charReady = 1'b0;
        do_read(A_STAT);
        chk("post_rst_status", last_bus, 8'h40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
